cp0_mmu_regs: RTL and testbench

Parametrised CP0 register file for the MIPS pipeline core. Adds the Random, Wired and Context registers, TLBWR support, a configurable Count prescaler and a registered interrupt-request output. It sits beside the writeback stage and feeds the TLB write/read ports and the fetch redirect logic. The TLB depth is generic.

---
 rtl/mycpu_cp0_pkg.sv | 90 +++++++++
 rtl/cp0_mmu_regs_if.sv | 14 +
 rtl/cp0_random_gen.sv | 52 +++++
 rtl/cp0_mmu_regs.sv | 230 +++++++++++++++++++++++
 tb/tb_cp0_mmu_regs.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mycpu_cp0_pkg.sv
// Shared CP0 definitions for the MIPS core.
// Contents: CP0 register addresses ({rd[4:0],sel[2:0]}), exception codes,
// register field positions, the packed CP0 state record and its reset value,
// and small excode classification helpers.
package mycpu_cp0_pkg;

  // CP0 address map, {rd, sel}
  localparam logic [7:0] CP0_INDEX    = 8'h00;
  localparam logic [7:0] CP0_RANDOM   = 8'h08;
  localparam logic [7:0] CP0_ENTRYLO0 = 8'h10;
  localparam logic [7:0] CP0_ENTRYLO1 = 8'h18;
  localparam logic [7:0] CP0_CONTEXT  = 8'h20;
  localparam logic [7:0] CP0_WIRED    = 8'h30;
  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_ENTRYHI  = 8'h50;
  localparam logic [7:0] CP0_COMPARE  = 8'h58;
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } excode_e;

  // Field positions
  localparam int unsigned STATUS_BEV        = 22;
  localparam int unsigned STATUS_IM_LO      = 8;
  localparam int unsigned STATUS_EXL        = 1;
  localparam int unsigned STATUS_IE         = 0;
  localparam int unsigned CAUSE_BD          = 31;
  localparam int unsigned CAUSE_TI          = 30;
  localparam int unsigned CAUSE_IP_LO       = 8;
  localparam int unsigned CAUSE_EXC_LO      = 2;
  localparam int unsigned ENTRYHI_VPN2_LO   = 13;
  localparam int unsigned CONTEXT_PTE_LO    = 23;
  localparam int unsigned CONTEXT_BADVPN_LO = 4;
  localparam int unsigned INDEX_P           = 31;

  // Architectural CP0 state except the parameter-sized Index/Random/Wired
  // and the Count prescaler.
  typedef struct packed {
    logic        index_p;
    logic [18:0] ehi_vpn2;
    logic [7:0]  ehi_asid;
    logic [25:0] elo0;       // {PFN, C, D, V, G}
    logic [25:0] elo1;
    logic [8:0]  ctx_pte;
    logic [18:0] ctx_badvpn2;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] epc;
    logic        st_bev;
    logic [7:0]  st_im;
    logic        st_exl;
    logic        st_ie;
    logic        ca_bd;
    logic        ca_ti;
    logic [7:0]  ca_ip;
    logic [4:0]  ca_exc;
    logic        int_req;
  } cp0_state_t;

  function automatic cp0_state_t cp0_reset_state();
    cp0_state_t s;
    s        = '0;
    s.st_bev = 1'b1;
    return s;
  endfunction

  // TLB-refill/invalid/modified faults also capture the VPN2
  function automatic logic exc_is_tlb(logic [4:0] code);
    return (code == EXC_MOD) || (code == EXC_TLBL) || (code == EXC_TLBS);
  endfunction

  function automatic logic exc_sets_badvaddr(logic [4:0] code);
    return exc_is_tlb(code) || (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_mmu_regs_if.sv
// MTC0/MFC0 access bus between the writeback stage and the CP0 register file.
//   mtc0_we   : MTC0 commit
//   cp0_addr  : {rd[4:0], sel[2:0]}
//   cp0_wdata : MTC0 data
//   cp0_rdata : MFC0 data (combinational from cp0_addr)
interface cp0_mmu_regs_if;
  logic        mtc0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;

  modport master (output mtc0_we, cp0_addr, cp0_wdata, input cp0_rdata);
  modport slave  (input mtc0_we, cp0_addr, cp0_wdata, output cp0_rdata);
endinterface

// File: rtl/cp0_random_gen.sv
// Random/Wired pair for TLBWR replacement.
//   clk, rst    : clock, synchronous active-high reset
//   wired_we    : MTC0 to Wired committing this cycle
//   wired_wdata : new Wired value
//   random      : current Random (TLBNUM-1 down to Wired, then reloads)
//   wired       : current Wired
module cp0_random_gen #(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wired_we,
  input  logic [IDXW-1:0] wired_wdata,
  output logic [IDXW-1:0] random,
  output logic [IDXW-1:0] wired
);

  localparam logic [IDXW-1:0] RAND_TOP = IDXW'(TLBNUM - 1);

  logic [IDXW-1:0] random_q, random_d;
  logic [IDXW-1:0] wired_q, wired_d;
  logic            wired_oob;

  // Wired outside the TLB pins Random at the top entry
  assign wired_oob = ({1'b0, wired_q} >= (IDXW + 1)'(TLBNUM));

  always_comb begin
    wired_d  = wired_q;
    random_d = random_q - 1'b1;
    if (wired_we) begin
      wired_d  = wired_wdata;
      random_d = RAND_TOP;
    end else if (wired_oob || (random_q == wired_q) || (random_q == '0)) begin
      random_d = RAND_TOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      random_q <= RAND_TOP;
      wired_q  <= '0;
    end else begin
      random_q <= random_d;
      wired_q  <= wired_d;
    end
  end

  assign random = random_q;
  assign wired  = wired_q;

endmodule

// File: rtl/cp0_mmu_regs.sv
// CP0 register file with MMU registers (Index, Random, EntryLo0/1, Context,
// Wired, EntryHi), Count/Compare timer with prescaler, Status/Cause/EPC/
// BadVAddr and a registered interrupt request.
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : MTC0 write / MFC0 read access
//   wb_ex/bd/eret/...   : writeback-stage exception and ERET commit
//   ext_int_in          : hardware interrupt lines
//   tlbp/tlbr/tlbwi/tlbwr, s_*, r_* : TLB instruction commit and TLB data
//   w_index             : TLB write index (Random for tlbwr, else Index)
//   entryhi..epc        : live register values
//   int_req             : registered interrupt request
module cp0_mmu_regs
  import mycpu_cp0_pkg::*;
#(
  parameter int unsigned TLBNUM    = 16,
  parameter int unsigned IDXW      = $clog2(TLBNUM),
  parameter int unsigned COUNT_DIV = 2,
  parameter int unsigned EXT_INT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  cp0_mmu_regs_if.slave        bus,
  input  logic                 wb_ex,
  input  logic                 wb_bd,
  input  logic                 wb_eret,
  input  logic [4:0]           wb_excode,
  input  logic [31:0]          wb_pc,
  input  logic [31:0]          wb_badvaddr,
  input  logic [EXT_INT_W-1:0] ext_int_in,
  input  logic                 tlbp,
  input  logic                 tlbr,
  input  logic                 tlbwi,
  input  logic                 tlbwr,
  input  logic                 s_found,
  input  logic [IDXW-1:0]      s_index,
  input  logic [18:0]          r_vpn2,
  input  logic [7:0]           r_asid,
  input  logic                 r_g,
  input  logic [19:0]          r_pfn0,
  input  logic [2:0]           r_c0,
  input  logic                 r_d0,
  input  logic                 r_v0,
  input  logic [19:0]          r_pfn1,
  input  logic [2:0]           r_c1,
  input  logic                 r_d1,
  input  logic                 r_v1,
  output logic [IDXW-1:0]      w_index,
  output logic [31:0]          entryhi,
  output logic [31:0]          entrylo0,
  output logic [31:0]          entrylo1,
  output logic [31:0]          status,
  output logic [31:0]          cause,
  output logic [31:0]          epc,
  output logic                 int_req
);

  localparam int unsigned     PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_TOP = PW'(COUNT_DIV - 1);

  cp0_state_t      st_q, st_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [IDXW-1:0] random_val, wired_val;
  logic            do_eret, do_tlbp, do_tlbr, do_mtc0, wired_we;
  logic [31:0]     wdata, rdata;

  assign wdata = bus.cp0_wdata;

  // One commit event wins per cycle; everything of lower priority is lost
  assign do_eret  = wb_eret & ~wb_ex;
  assign do_tlbp  = tlbp & ~wb_ex & ~wb_eret;
  assign do_tlbr  = tlbr & ~wb_ex & ~wb_eret;
  assign do_mtc0  = bus.mtc0_we & ~wb_ex & ~wb_eret & ~tlbp & ~tlbr;
  assign wired_we = do_mtc0 && (bus.cp0_addr == CP0_WIRED);

  cp0_random_gen #(
    .TLBNUM(TLBNUM),
    .IDXW  (IDXW)
  ) u_random (
    .clk        (clk),
    .rst        (rst),
    .wired_we   (wired_we),
    .wired_wdata(wdata[IDXW-1:0]),
    .random     (random_val),
    .wired      (wired_val)
  );

  // Later assignments override earlier ones, so the blocks below are in
  // ascending priority: free-running timers, MTC0, TLB, ERET, exception.
  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    presc_d = presc_q + 1'b1;

    if (presc_q == PRESC_TOP) begin
      presc_d    = '0;
      st_d.count = st_q.count + 32'd1;
    end
    if (st_q.count == st_q.compare) st_d.ca_ti = 1'b1;
    st_d.ca_ip[7]   = ext_int_in[5] | st_q.ca_ti;
    st_d.ca_ip[6:2] = ext_int_in[4:0];
    st_d.int_req    = st_q.st_ie & ~st_q.st_exl & (|(st_q.ca_ip & st_q.st_im));

    if (do_mtc0) begin
      case (bus.cp0_addr)
        CP0_INDEX:    idx_d = wdata[IDXW-1:0];
        CP0_ENTRYLO0: st_d.elo0 = wdata[25:0];
        CP0_ENTRYLO1: st_d.elo1 = wdata[25:0];
        CP0_CONTEXT:  st_d.ctx_pte = wdata[31:CONTEXT_PTE_LO];
        CP0_COUNT: begin
          st_d.count = wdata;
          presc_d    = '0;
        end
        CP0_ENTRYHI: begin
          st_d.ehi_vpn2 = wdata[31:ENTRYHI_VPN2_LO];
          st_d.ehi_asid = wdata[7:0];
        end
        CP0_COMPARE: begin
          st_d.compare = wdata;
          st_d.ca_ti   = 1'b0;
        end
        CP0_STATUS: begin
          st_d.st_bev = wdata[STATUS_BEV];
          st_d.st_im  = wdata[STATUS_IM_LO +: 8];
          st_d.st_exl = wdata[STATUS_EXL];
          st_d.st_ie  = wdata[STATUS_IE];
        end
        CP0_CAUSE:    st_d.ca_ip[1:0] = wdata[CAUSE_IP_LO +: 2];
        default: ;
      endcase
    end

    if (do_tlbp) begin
      st_d.index_p = ~s_found;
      if (s_found) idx_d = s_index;
    end
    if (do_tlbr) begin
      st_d.ehi_vpn2 = r_vpn2;
      st_d.ehi_asid = r_asid;
      st_d.elo0     = {r_pfn0, r_c0, r_d0, r_v0, r_g};
      st_d.elo1     = {r_pfn1, r_c1, r_d1, r_v1, r_g};
    end

    if (do_eret) st_d.st_exl = 1'b0;

    if (wb_ex) begin
      st_d.st_exl = 1'b1;
      st_d.ca_exc = wb_excode;
      // A nested exception keeps the original return point
      if (!st_q.st_exl) begin
        st_d.ca_bd = wb_bd;
        st_d.epc   = wb_bd ? (wb_pc - 32'd4) : wb_pc;
      end
      if (exc_sets_badvaddr(wb_excode)) st_d.badvaddr = wb_badvaddr;
      if (exc_is_tlb(wb_excode)) begin
        st_d.ehi_vpn2    = wb_badvaddr[31:ENTRYHI_VPN2_LO];
        st_d.ctx_badvpn2 = wb_badvaddr[31:ENTRYHI_VPN2_LO];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= cp0_reset_state();
      idx_q   <= '0;
      presc_q <= '0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
    end
  end

  // Register views
  always_comb begin
    entryhi = '0;
    entryhi[ENTRYHI_VPN2_LO +: 19] = st_q.ehi_vpn2;
    entryhi[7:0] = st_q.ehi_asid;

    entrylo0 = {6'b0, st_q.elo0};
    entrylo1 = {6'b0, st_q.elo1};

    status = '0;
    status[STATUS_BEV]        = st_q.st_bev;
    status[STATUS_IM_LO +: 8] = st_q.st_im;
    status[STATUS_EXL]        = st_q.st_exl;
    status[STATUS_IE]         = st_q.st_ie;

    cause = '0;
    cause[CAUSE_BD]          = st_q.ca_bd;
    cause[CAUSE_TI]          = st_q.ca_ti;
    cause[CAUSE_IP_LO +: 8]  = st_q.ca_ip;
    cause[CAUSE_EXC_LO +: 5] = st_q.ca_exc;
  end

  assign epc     = st_q.epc;
  assign int_req = st_q.int_req;

  // tlbwi and tlbwr are one-hot, so tlbwi never selects Random
  assign w_index = (tlbwr & ~tlbwi) ? random_val : idx_q;

  always_comb begin
    rdata = '0;
    case (bus.cp0_addr)
      CP0_INDEX: begin
        rdata[INDEX_P]    = st_q.index_p;
        rdata[IDXW-1:0]   = idx_q;
      end
      CP0_RANDOM:   rdata[IDXW-1:0] = random_val;
      CP0_ENTRYLO0: rdata = entrylo0;
      CP0_ENTRYLO1: rdata = entrylo1;
      CP0_CONTEXT: begin
        rdata[31:CONTEXT_PTE_LO]       = st_q.ctx_pte;
        rdata[CONTEXT_BADVPN_LO +: 19] = st_q.ctx_badvpn2;
      end
      CP0_WIRED:    rdata[IDXW-1:0] = wired_val;
      CP0_BADVADDR: rdata = st_q.badvaddr;
      CP0_COUNT:    rdata = st_q.count;
      CP0_ENTRYHI:  rdata = entryhi;
      CP0_COMPARE:  rdata = st_q.compare;
      CP0_STATUS:   rdata = status;
      CP0_CAUSE:    rdata = cause;
      CP0_EPC:      rdata = st_q.epc;
      default: ;
    endcase
  end

  assign bus.cp0_rdata = rdata;

endmodule

// File: tb/tb_cp0_mmu_regs.sv
// Scoreboard bench for cp0_mmu_regs: the stimulus process queues expected
// values for the current cycle, the monitor pops and compares them on the
// falling edge.
module tb_cp0_mmu_regs;
  import mycpu_cp0_pkg::*;

  localparam int unsigned TLBNUM = 16;
  localparam int unsigned IDXW   = 4;

  localparam int SEL_RDATA = 0, SEL_WIDX = 1, SEL_INTREQ = 2, SEL_EHI = 3,
                 SEL_ELO0 = 4, SEL_ELO1 = 5, SEL_STATUS = 6, SEL_CAUSE = 7,
                 SEL_EPC = 8;

  logic clk = 1'b0;
  logic rst;
  logic wb_ex, wb_bd, wb_eret;
  logic [4:0] wb_excode;
  logic [31:0] wb_pc, wb_badvaddr;
  logic [5:0] ext_int_in;
  logic tlbp, tlbr, tlbwi, tlbwr, s_found;
  logic [IDXW-1:0] s_index, w_index;
  logic [18:0] r_vpn2;
  logic [7:0] r_asid;
  logic r_g, r_d0, r_v0, r_d1, r_v1;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0] r_c0, r_c1;
  logic [31:0] entryhi, entrylo0, entrylo1, status, cause, epc;
  logic int_req;

  cp0_mmu_regs_if bus();

  cp0_mmu_regs #(
    .TLBNUM   (TLBNUM),
    .IDXW     (IDXW),
    .COUNT_DIV(2),
    .EXT_INT_W(6)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .wb_ex(wb_ex), .wb_bd(wb_bd), .wb_eret(wb_eret), .wb_excode(wb_excode),
    .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .ext_int_in(ext_int_in),
    .tlbp(tlbp), .tlbr(tlbr), .tlbwi(tlbwi), .tlbwr(tlbwr),
    .s_found(s_found), .s_index(s_index),
    .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .w_index(w_index), .entryhi(entryhi), .entrylo0(entrylo0),
    .entrylo1(entrylo1), .status(status), .cause(cause), .epc(epc),
    .int_req(int_req)
  );

  always #5 clk = ~clk;

  string       nm_q[$];
  int          sel_q[$];
  logic [31:0] exp_q[$];
  int          chk_n = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      SEL_RDATA:  return bus.cp0_rdata;
      SEL_WIDX:   return 32'(w_index);
      SEL_INTREQ: return 32'(int_req);
      SEL_EHI:    return entryhi;
      SEL_ELO0:   return entrylo0;
      SEL_ELO1:   return entrylo1;
      SEL_STATUS: return status;
      SEL_CAUSE:  return cause;
      default:    return epc;
    endcase
  endfunction

  task automatic push_exp(input string nm, input int sel, input logic [31:0] v);
    nm_q.push_back(nm);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    chk_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk_n = 0;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    bus.mtc0_we   = 1'b1;
    bus.cp0_addr  = a;
    bus.cp0_wdata = d;
  endtask

  task automatic idle();
    bus.mtc0_we = 1'b0;
    wb_ex = 1'b0; wb_eret = 1'b0;
    tlbp = 1'b0; tlbr = 1'b0; tlbwi = 1'b0; tlbwr = 1'b0;
  endtask

  task automatic raise_ex(input logic [4:0] code, input logic bd,
                          input logic [31:0] pc, input logic [31:0] bva);
    wb_ex = 1'b1; wb_excode = code; wb_bd = bd; wb_pc = pc; wb_badvaddr = bva;
  endtask

  // Monitor
  always @(negedge clk) begin
    for (int i = 0; i < chk_n; i++) begin
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow at %0t", $time);
      end else begin
        string       nm;
        int          sel;
        logic [31:0] ev, got;
        nm  = nm_q.pop_front();
        sel = sel_q.pop_front();
        ev  = exp_q.pop_front();
        got = observe(sel);
        n_cmp++;
        if (got !== ev) begin
          n_bad++;
          $display("FAIL %s: got %08h required %08h (t=%0t)", nm, got, ev, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    bus.cp0_addr = '0; bus.cp0_wdata = '0;
    wb_bd = 1'b0; wb_excode = '0; wb_pc = '0; wb_badvaddr = '0;
    ext_int_in = '0; s_found = 1'b0; s_index = '0;
    r_vpn2 = '0; r_asid = '0; r_g = 1'b0;
    r_pfn0 = '0; r_c0 = '0; r_d0 = 1'b0; r_v0 = 1'b0;
    r_pfn1 = '0; r_c1 = '0; r_d1 = 1'b0; r_v1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values, then Random walks 15..0 and reloads with Wired=0
    bus.cp0_addr = CP0_RANDOM;
    for (int c = 0; c < 17; c++) begin
      push_exp("random_w0", SEL_RDATA, (c == 16) ? 32'd15 : 32'(15 - c));
      if (c == 0) begin
        push_exp("rst_status", SEL_STATUS, 32'h0040_0000);
        push_exp("rst_cause", SEL_CAUSE, 32'h0);
        push_exp("rst_epc", SEL_EPC, 32'h0);
        push_exp("rst_entryhi", SEL_EHI, 32'h0);
        push_exp("rst_entrylo0", SEL_ELO0, 32'h0);
        push_exp("rst_int_req", SEL_INTREQ, 32'h0);
        push_exp("rst_w_index", SEL_WIDX, 32'h0);
      end
      if (c == 1) push_exp("ti_at_reset", SEL_CAUSE, 32'h4000_0000);
      if (c == 2) push_exp("ip7_at_reset", SEL_CAUSE, 32'h4000_8000);
      if (c == 3) push_exp("int_req_ie0", SEL_INTREQ, 32'h0);
      tick();
    end

    // Wired=4: Random reloads immediately and walks 15..4
    mtc0(CP0_WIRED, 32'h0000_0004);
    push_exp("wired_before", SEL_RDATA, 32'h0);
    tick();
    idle();
    bus.cp0_addr = CP0_RANDOM;
    for (int k = 0; k < 13; k++) begin
      tlbwr = (k == 6);
      push_exp("random_w4", SEL_RDATA, (k == 12) ? 32'd15 : 32'(15 - k));
      if (k == 6) push_exp("tlbwr_w_index", SEL_WIDX, 32'd9);
      tick();
    end
    idle();
    bus.cp0_addr = CP0_WIRED;
    push_exp("wired_read", SEL_RDATA, 32'd4);
    tick();
    tlbwi = 1'b1;
    push_exp("tlbwi_w_index", SEL_WIDX, 32'd0);
    tick();
    idle();

    // Timer: Compare=10, Count=0, prescale by 2
    mtc0(CP0_COMPARE, 32'd10);
    tick();
    mtc0(CP0_COUNT, 32'd0);
    tick();
    for (int j = 0; j < 27; j++) begin
      idle();
      if (j == 0) mtc0(CP0_STATUS, 32'h0040_8001);
      if (j == 10) begin
        bus.cp0_addr = CP0_COUNT;
        push_exp("count_prescaled", SEL_RDATA, 32'd5);
      end
      if (j == 20) push_exp("ti_not_yet", SEL_CAUSE, 32'h0);
      if (j == 21) push_exp("ti_set", SEL_CAUSE, 32'h4000_0000);
      if (j == 22) begin
        push_exp("ip7_set", SEL_CAUSE, 32'h4000_8000);
        push_exp("int_req_lag", SEL_INTREQ, 32'h0);
      end
      if (j == 23) begin
        push_exp("int_req_timer", SEL_INTREQ, 32'h1);
        mtc0(CP0_COMPARE, 32'h100);
      end
      if (j == 24) push_exp("ti_cleared", SEL_CAUSE, 32'h0000_8000);
      if (j == 25) begin
        push_exp("ip7_cleared", SEL_CAUSE, 32'h0);
        push_exp("int_req_tail", SEL_INTREQ, 32'h1);
      end
      if (j == 26) push_exp("int_req_drop", SEL_INTREQ, 32'h0);
      tick();
    end
    idle();

    // External interrupt line 2 -> IP4, two cycles to int_req
    mtc0(CP0_STATUS, 32'h0040_1001);
    tick();
    idle();
    ext_int_in = 6'b000100;
    push_exp("ext_int_req0", SEL_INTREQ, 32'h0);
    tick();
    ext_int_in = '0;
    push_exp("ext_ip4", SEL_CAUSE, 32'h0000_1000);
    push_exp("ext_int_req1", SEL_INTREQ, 32'h0);
    tick();
    push_exp("ext_int_req2", SEL_INTREQ, 32'h1);
    tick();

    // TLBL exception in a delay slot, then a nested AdEL
    raise_ex(5'd2, 1'b1, 32'h8000_1004, 32'h1234_5678);
    tick();
    idle();
    bus.cp0_addr = CP0_CONTEXT;
    push_exp("ex_epc", SEL_EPC, 32'h8000_1000);
    push_exp("ex_cause", SEL_CAUSE, 32'h8000_0008);
    push_exp("ex_status", SEL_STATUS, 32'h0040_1003);
    push_exp("ex_entryhi", SEL_EHI, 32'h1234_4000);
    push_exp("ex_context", SEL_RDATA, 32'h0009_1A20);
    push_exp("ex_int_masked", SEL_INTREQ, 32'h0);
    tick();
    bus.cp0_addr = CP0_BADVADDR;
    push_exp("ex_badvaddr", SEL_RDATA, 32'h1234_5678);
    raise_ex(5'd4, 1'b0, 32'h8000_2000, 32'hDEAD_0000);
    tick();
    idle();
    wb_eret = 1'b1;
    push_exp("nest_epc", SEL_EPC, 32'h8000_1000);
    push_exp("nest_cause", SEL_CAUSE, 32'h8000_0010);
    push_exp("nest_badvaddr", SEL_RDATA, 32'hDEAD_0000);
    push_exp("nest_entryhi", SEL_EHI, 32'h1234_4000);
    tick();
    idle();
    push_exp("eret_status", SEL_STATUS, 32'h0040_1001);
    // Exception and MTC0 Status in the same cycle
    raise_ex(5'd8, 1'b0, 32'h8000_3000, 32'h0);
    mtc0(CP0_STATUS, 32'h0);
    tick();
    idle();
    push_exp("exmtc0_status", SEL_STATUS, 32'h0040_1003);
    push_exp("exmtc0_epc", SEL_EPC, 32'h8000_3000);
    push_exp("exmtc0_cause", SEL_CAUSE, 32'h0000_0020);
    wb_eret = 1'b1;
    tick();
    idle();
    push_exp("eret2_status", SEL_STATUS, 32'h0040_1001);
    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    tick();
    idle();
    push_exp("cause_sw_ip", SEL_CAUSE, 32'h0000_0320);
    tick();

    // TLBP miss / hit, Index write masking, TLBR
    tlbp = 1'b1; s_found = 1'b0; s_index = 4'd3;
    tick();
    idle();
    bus.cp0_addr = CP0_INDEX;
    tlbwi = 1'b1;
    push_exp("tlbp_miss_index", SEL_RDATA, 32'h8000_0000);
    push_exp("tlbp_miss_widx", SEL_WIDX, 32'd0);
    tick();
    idle();
    tlbp = 1'b1; s_found = 1'b1; s_index = 4'd5;
    tick();
    idle();
    tlbwi = 1'b1;
    push_exp("tlbp_hit_index", SEL_RDATA, 32'h0000_0005);
    push_exp("tlbp_hit_widx", SEL_WIDX, 32'd5);
    tick();
    idle();
    mtc0(CP0_INDEX, 32'hFFFF_FFFF);
    tick();
    idle();
    push_exp("index_p_ro", SEL_RDATA, 32'h0000_000F);
    tlbr = 1'b1;
    r_vpn2 = 19'h2_3456; r_asid = 8'hA5; r_g = 1'b1;
    r_pfn0 = 20'hABCDE; r_c0 = 3'd3; r_d0 = 1'b1; r_v0 = 1'b0;
    r_pfn1 = 20'h12345; r_c1 = 3'd2; r_d1 = 1'b0; r_v1 = 1'b1;
    tick();
    idle();
    bus.cp0_addr = CP0_ENTRYLO0;
    push_exp("tlbr_entryhi", SEL_EHI, 32'h468A_C0A5);
    push_exp("tlbr_entrylo0", SEL_ELO0, 32'h02AF_379D);
    push_exp("tlbr_entrylo1", SEL_ELO1, 32'h0048_D153);
    push_exp("tlbr_rd_elo0", SEL_RDATA, 32'h02AF_379D);
    tick();
    mtc0(CP0_ENTRYHI, 32'hFFFF_FFFF);
    tick();
    idle();
    bus.cp0_addr = 8'h78;
    push_exp("entryhi_mask", SEL_EHI, 32'hFFFF_E0FF);
    push_exp("unmapped_read", SEL_RDATA, 32'h0);
    tick();
    tick();

    if (exp_q.size() != 0) begin
      n_bad += exp_q.size();
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
